ccd_acq_ctrl: RTL

- Acquisition sequencer for the linear-CCD timing driver. Programs the driver's line-period word (f_cnt) and retimes the driver's os_tvalid.
- Gates whole lines into a frame of N lines, in free-run or external-trigger mode, and reports frame start, done, abort and missed-trigger events to the downstream AD/capture path.

---
 rtl/ccd_pkg.sv | 20 ++
 rtl/sync_edge.sv | 37 +++
 rtl/ccd_acq_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ccd_pkg.sv
// Shared types and constants for the linear-CCD acquisition sequencer.
package ccd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_ACQ  = 2'd2
    } ccd_state_e;

    localparam int unsigned PERIOD_MIN = 2102;
    localparam int unsigned PERIOD_DEF = 10000;
    localparam int unsigned LINE_WIDTH = 2088;
    localparam int unsigned F_W        = 23;

    function automatic logic [F_W-1:0] clamp_period(input logic [F_W-1:0] req,
                                                    input logic [F_W-1:0] pmin);
        return (req < pmin) ? pmin : req;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by an edge register; reports the retimed level and its edges.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q, dly_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign rise = sync_q & ~dly_q;
    assign fall = ~sync_q & dly_q;
    assign lvl  = dly_q;

endmodule

// File: rtl/ccd_acq_ctrl.sv
// Acquisition sequencer: programs the line period and gates whole CCD lines into frames.
//   state | meaning
//   IDLE  | f_cnt tracks cfg_period, waiting for start
//   ARM   | frame requested, waiting for the first accepted line boundary
//   ACQ   | capturing lines until the frame count is reached or a stop lands
module ccd_acq_ctrl #(
    parameter int unsigned PERIOD_MIN = ccd_pkg::PERIOD_MIN,
    parameter int unsigned PERIOD_DEF = ccd_pkg::PERIOD_DEF,
    parameter int unsigned LCNT_W     = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [22:0]       cfg_period,
    input  logic [LCNT_W-1:0] cfg_lines,
    input  logic              cfg_trig_mode,
    input  logic              cfg_cont,
    input  logic              start,
    input  logic              stop,
    input  logic              ext_trig,
    input  logic              os_tvalid,
    output logic [22:0]       f_cnt,
    output logic              acq_tvalid,
    output logic [LCNT_W-1:0] line_cnt,
    output logic              busy,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              trig_miss
);
    import ccd_pkg::*;

    localparam logic [22:0] P_MIN = 23'(PERIOD_MIN);
    localparam logic [22:0] P_DEF = 23'(PERIOD_DEF);

    logic tv_lvl, tv_rise, tv_fall;
    logic tg_lvl, tg_rise, tg_fall;
    logic trig_unused;

    sync_edge u_sync_tvalid (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d_in  (os_tvalid),
        .lvl   (tv_lvl),
        .rise  (tv_rise),
        .fall  (tv_fall)
    );

    sync_edge u_sync_trig (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d_in  (ext_trig),
        .lvl   (tg_lvl),
        .rise  (tg_rise),
        .fall  (tg_fall)
    );

    // only the trigger's rising edge is an event
    assign trig_unused = tg_lvl | tg_fall;

    ccd_state_e        state_q, state_d;
    logic [22:0]       f_cnt_q, f_cnt_d;
    logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [LCNT_W-1:0] lines_l_q, lines_l_d;
    logic              mode_l_q, mode_l_d;
    logic              line_act_q, line_act_d;
    logic              trig_pend_q, trig_pend_d;
    logic              stop_pend_q, stop_pend_d;
    logic              acq_tvalid_q, acq_tvalid_d;
    logic              busy_q, busy_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_abort_q, frame_abort_d;
    logic              trig_miss_q, trig_miss_d;

    logic [22:0]       p_clamped;
    logic [LCNT_W-1:0] cnt_inc;
    logic              accept;
    logic              stop_now;

    always_comb begin
        state_d       = state_q;
        f_cnt_d       = f_cnt_q;
        line_cnt_d    = line_cnt_q;
        lines_l_d     = lines_l_q;
        mode_l_d      = mode_l_q;
        line_act_d    = line_act_q;
        trig_pend_d   = trig_pend_q;
        stop_pend_d   = stop_pend_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        trig_miss_d   = 1'b0;
        p_clamped     = clamp_period(cfg_period, P_MIN);
        cnt_inc       = line_cnt_q + LCNT_W'(1);
        stop_now      = stop | stop_pend_q;
        accept        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                f_cnt_d     = p_clamped;
                line_act_d  = 1'b0;
                trig_pend_d = 1'b0;
                stop_pend_d = 1'b0;
                if (start) begin
                    lines_l_d  = (cfg_lines == '0) ? LCNT_W'(1) : cfg_lines;
                    mode_l_d   = cfg_trig_mode;
                    line_cnt_d = '0;
                    state_d    = ST_ARM;
                end
            end
            default: begin
                if (tv_fall) f_cnt_d = p_clamped;

                if (mode_l_q && tg_rise) begin
                    if (trig_pend_q || line_act_q) trig_miss_d = 1'b1;
                    else                           trig_pend_d = 1'b1;
                end

                accept = tv_rise && (!mode_l_q || trig_pend_q);
                if (accept) begin
                    if (mode_l_q) trig_pend_d = 1'b0;
                    line_act_d = 1'b1;
                    // a zero count at an accepted rise means this line opens a frame
                    if (line_cnt_q == '0) frame_start_d = 1'b1;
                    state_d = ST_ACQ;
                end

                if (tv_fall && line_act_q) begin
                    line_act_d = 1'b0;
                    line_cnt_d = cnt_inc;
                    if (cnt_inc == lines_l_q) begin
                        frame_done_d = 1'b1;
                        if (cfg_cont && !stop_now) line_cnt_d = '0;
                        else                       state_d    = ST_IDLE;
                    end else if (stop_now) begin
                        frame_abort_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end

                if (stop) begin
                    if (!line_act_q) begin
                        frame_abort_d = 1'b1;
                        frame_start_d = 1'b0;
                        line_act_d    = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        stop_pend_d = 1'b1;
                    end
                end
            end
        endcase

        acq_tvalid_d = tv_lvl & line_act_q;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            f_cnt_q       <= P_DEF;
            line_cnt_q    <= '0;
            lines_l_q     <= '0;
            mode_l_q      <= 1'b0;
            line_act_q    <= 1'b0;
            trig_pend_q   <= 1'b0;
            stop_pend_q   <= 1'b0;
            acq_tvalid_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            trig_miss_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            f_cnt_q       <= f_cnt_d;
            line_cnt_q    <= line_cnt_d;
            lines_l_q     <= lines_l_d;
            mode_l_q      <= mode_l_d;
            line_act_q    <= line_act_d;
            trig_pend_q   <= trig_pend_d;
            stop_pend_q   <= stop_pend_d;
            acq_tvalid_q  <= acq_tvalid_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
            trig_miss_q   <= trig_miss_d;
        end
    end

    assign f_cnt       = f_cnt_q;
    assign acq_tvalid  = acq_tvalid_q;
    assign line_cnt    = line_cnt_q;
    assign busy        = busy_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign trig_miss   = trig_miss_q;

endmodule
